// File: rtl/wb_write_arbiter.sv
// Round-robin write-back arbiter for the dual-write-port register file.
// Packs two non-colliding single writes into one cycle; outputs are registered.
module wb_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_dual,
  input  logic [3*NUM_REQ-1:0]    req_addr0,
  input  logic [3*NUM_REQ-1:0]    req_addr1,
  input  logic [16*NUM_REQ-1:0]   req_data0,
  input  logic [16*NUM_REQ-1:0]   req_data1,
  output logic                    reg_write_en,
  output logic [1:0]              write_mode,
  output logic [2:0]              reg_write_addr_0,
  output logic [2:0]              reg_write_addr_1,
  output logic [15:0]             data_in_0,
  output logic [15:0]             data_in_1,
  output logic [CNT_W-1:0]        pack_count,
  output logic [CNT_W-1:0]        conflict_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] rr_ptr, rr_next;
  logic [2:0]       a0 [NUM_REQ];
  logic [2:0]       a1 [NUM_REQ];
  logic [15:0]      d0 [NUM_REQ];
  logic [15:0]      d1 [NUM_REQ];

  logic             found_w, found_s, cand_seen, do_pack, do_conflict;
  logic [PTR_W-1:0] w_idx, s_idx, idx, last_idx;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]       n_mode;
  logic [2:0]       n_a0, n_a1;
  logic [15:0]      n_d0, n_d1;

  function automatic logic [PTR_W-1:0] scan_at(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = {{(32-PTR_W){1'b0}}, p} + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a0[i] = req_addr0[3*i +: 3];
      a1[i] = req_addr1[3*i +: 3];
      d0[i] = req_data0[16*i +: 16];
      d1[i] = req_data1[16*i +: 16];
    end
  end

  // W is the first valid requester from rr_ptr; every later valid single is a
  // pairing candidate, and S is the first of those with a different addr0.
  always_comb begin
    found_w   = 1'b0;
    found_s   = 1'b0;
    cand_seen = 1'b0;
    w_idx     = '0;
    s_idx     = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = scan_at(rr_ptr, k);
      if (req_valid[idx]) begin
        if (!found_w) begin
          found_w = 1'b1;
          w_idx   = idx;
        end else if (!req_dual[w_idx] && !req_dual[idx]) begin
          cand_seen = 1'b1;
          if (!found_s && (a0[idx] != a0[w_idx])) begin
            found_s = 1'b1;
            s_idx   = idx;
          end
        end
      end
    end
  end

  always_comb begin
    grant  = '0;
    n_mode = 2'b00;
    n_a0   = '0;
    n_a1   = '0;
    n_d0   = '0;
    n_d1   = '0;
    if (found_w) begin
      grant[w_idx] = 1'b1;
      if (req_dual[w_idx]) begin
        n_a0 = a0[w_idx];
        if (a0[w_idx] != a1[w_idx]) begin
          n_mode = 2'b11;
          n_d0   = d0[w_idx];
          n_a1   = a1[w_idx];
          n_d1   = d1[w_idx];
        end else begin
          n_mode = 2'b01;
          n_d0   = d1[w_idx];
        end
      end else begin
        n_a0 = a0[w_idx];
        n_d0 = d0[w_idx];
        if (found_s) begin
          grant[s_idx] = 1'b1;
          n_mode = 2'b11;
          n_a1   = a0[s_idx];
          n_d1   = d0[s_idx];
        end else begin
          n_mode = 2'b01;
        end
      end
    end
  end

  assign req_ready   = grant;
  assign do_pack     = found_w && found_s;
  assign do_conflict = found_w && !req_dual[w_idx] && cand_seen && !found_s;
  assign last_idx    = found_s ? s_idx : w_idx;
  assign rr_next     = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr           <= '0;
      reg_write_en     <= 1'b0;
      write_mode       <= 2'b00;
      reg_write_addr_0 <= '0;
      reg_write_addr_1 <= '0;
      data_in_0        <= '0;
      data_in_1        <= '0;
      pack_count       <= '0;
      conflict_count   <= '0;
    end else begin
      if (found_w) rr_ptr <= rr_next;
      reg_write_en     <= (n_mode != 2'b00);
      write_mode       <= n_mode;
      reg_write_addr_0 <= n_a0;
      reg_write_addr_1 <= n_a1;
      data_in_0        <= n_d0;
      data_in_1        <= n_d1;
      if (do_pack && (pack_count != '1)) pack_count <= pack_count + 1'b1;
      if (do_conflict && (conflict_count != '1)) conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_write_arbiter;
  localparam int unsigned N = 3;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_dual = '0;
  logic [3*N-1:0]  req_addr0 = '0;
  logic [3*N-1:0]  req_addr1 = '0;
  logic [16*N-1:0] req_data0 = '0;
  logic [16*N-1:0] req_data1 = '0;
  logic            reg_write_en;
  logic [1:0]      write_mode;
  logic [2:0]      reg_write_addr_0, reg_write_addr_1;
  logic [15:0]     data_in_0, data_in_1;
  logic [CW-1:0]   pack_count, conflict_count;

  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic [2:0]  a1;
    logic [15:0] d1;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  failures = 0;
  logic mon_en = 1'b0;

  wb_write_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dual(req_dual),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .reg_write_en(reg_write_en), .write_mode(write_mode),
    .reg_write_addr_0(reg_write_addr_0), .reg_write_addr_1(reg_write_addr_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .pack_count(pack_count), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t act, exp;
      act = '{write_mode, reg_write_addr_0, data_in_0, reg_write_addr_1, data_in_1};
      checks++;
      if (reg_write_en) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=%h required=none", act);
        end else begin
          exp = q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL write actual=%h required=%h", act, exp);
          end
        end
      end else if (act !== '0) begin
        failures++;
        $display("FAIL idle_outputs actual=%h required=0", act);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic dual, input logic [2:0] x0,
                         input logic [2:0] x1, input logic [15:0] y0, input logic [15:0] y1);
    req_dual[i]          = dual;
    req_addr0[3*i +: 3]  = x0;
    req_addr1[3*i +: 3]  = x1;
    req_data0[16*i +: 16] = y0;
    req_data1[16*i +: 16] = y1;
  endtask

  // Called at a negedge with inputs applied; checks ready, queues the write, waits a cycle.
  task automatic step(input logic [N-1:0] exp_ready, input logic push, input wr_t e);
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (push) q.push_back(e);
    @(negedge clk);
  endtask

  localparam wr_t NONE = '0;

  initial begin
    wr_t rot [3];
    logic [N-1:0] rot_ready [3];

    #2 rst = 1'b1;
    #1;
    chk("reset_en", 32'(reg_write_en), 0);
    chk("reset_mode", 32'(write_mode), 0);
    chk("reset_pack", 32'(pack_count), 0);
    chk("reset_conflict", 32'(conflict_count), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) step('0, 1'b0, NONE);

    // Pair of distinct singles packs into one cycle
    set_req(0, 0, 3'd2, 3'd0, 16'h1234, 16'h0);
    set_req(1, 0, 3'd5, 3'd0, 16'hBEEF, 16'h0);
    req_valid = 3'b011;
    step(3'b011, 1'b1, '{2'b11, 3'd2, 16'h1234, 3'd5, 16'hBEEF});
    req_valid = '0;
    chk("pack_after_pair", 32'(pack_count), 1);

    // Same-address singles (rr_ptr 2): req0 wins, req1 follows
    set_req(0, 0, 3'd3, 3'd0, 16'h0333, 16'h0);
    set_req(1, 0, 3'd3, 3'd0, 16'h1333, 16'h0);
    req_valid = 3'b011;
    step(3'b001, 1'b1, '{2'b01, 3'd3, 16'h0333, 3'd0, 16'h0});
    req_valid = 3'b010;
    chk("conflict_count", 32'(conflict_count), 1);
    step(3'b010, 1'b1, '{2'b01, 3'd3, 16'h1333, 3'd0, 16'h0});

    // Dual at rr_ptr 2 is never paired with the waiting single
    set_req(2, 1, 3'd6, 3'd7, 16'hAAAA, 16'h5555);
    set_req(0, 0, 3'd4, 3'd0, 16'h0444, 16'h0);
    req_valid = 3'b101;
    step(3'b100, 1'b1, '{2'b11, 3'd6, 16'hAAAA, 3'd7, 16'h5555});
    req_valid = 3'b001;
    step(3'b001, 1'b1, '{2'b01, 3'd4, 16'h0444, 3'd0, 16'h0});

    // Dual to the same register: data1 wins
    set_req(1, 1, 3'd1, 3'd1, 16'h1111, 16'h2222);
    req_valid = 3'b010;
    step(3'b010, 1'b1, '{2'b01, 3'd1, 16'h2222, 3'd0, 16'h0});
    req_valid = '0;
    chk("pack_unchanged", 32'(pack_count), 1);
    chk("conflict_unchanged", 32'(conflict_count), 1);

    // Reset while a write is on the outputs drops it asynchronously
    set_req(0, 0, 3'd2, 3'd0, 16'h7777, 16'h0);
    req_valid = 3'b001;
    #1 chk("ready_before_rst", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 chk("write_present", 32'(reg_write_en), 1);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(reg_write_en), 0);
    chk("midrst_addr_data", {13'(0), reg_write_addr_0, data_in_0}, 0);
    chk("midrst_pack", 32'(pack_count), 0);
    chk("midrst_conflict", 32'(conflict_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Three distinct singles held valid: 3-cycle rotation, pack_count saturates at 3
    set_req(0, 0, 3'd1, 3'd0, 16'hA001, 16'h0);
    set_req(1, 0, 3'd2, 3'd0, 16'hA002, 16'h0);
    set_req(2, 0, 3'd3, 3'd0, 16'hA003, 16'h0);
    rot[0] = '{2'b11, 3'd1, 16'hA001, 3'd2, 16'hA002}; rot_ready[0] = 3'b011;
    rot[1] = '{2'b11, 3'd3, 16'hA003, 3'd1, 16'hA001}; rot_ready[1] = 3'b101;
    rot[2] = '{2'b11, 3'd2, 16'hA002, 3'd3, 16'hA003}; rot_ready[2] = 3'b110;
    req_valid = 3'b111;
    for (int unsigned k = 0; k < 20; k++) begin
      chk("pack_sat", 32'(pack_count), (k < 3) ? k : 3);
      step(rot_ready[k % 3], 1'b1, rot[k % 3]);
    end
    req_valid = '0;
    chk("pack_final", 32'(pack_count), 3);
    chk("conflict_final", 32'(conflict_count), 0);
    repeat (2) step('0, 1'b0, NONE);
    chk("queue_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-back arbiter for the 8x16-bit two-write-port register file.
- Collects write requests from NUM_REQ pipeline sources (e.g. ALU, LSU, MUL) over valid/ready handshakes.
- Arbitrates round-robin and packs two independent single-register writes into one dual-port write cycle when legal.
- Drives the register-file write interface from registered outputs (write_mode 00/01/11).

Parameters:
NUM_REQ, 3, number of requesters; supported range 2..4
CNT_W, 16, width of saturating performance counters

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  request i valid
req_ready  output  NUM_REQ  request i accepted this cycle (combinational)
req_dual  input  NUM_REQ  1: two-register write (addr0/data0 and addr1/data1); 0: single write (addr0/data0)
req_addr0  input  3*NUM_REQ  first destination, slice [3i+2:3i]
req_addr1  input  3*NUM_REQ  second destination, used only if req_dual
req_data0  input  16*NUM_REQ  data for addr0, slice [16i+15:16i]
req_data1  input  16*NUM_REQ  data for addr1
reg_write_en  output  1  register-file write enable
write_mode  output  2  00 none, 01 port 0 only, 11 both ports
reg_write_addr_0  output  3  port 0 address
reg_write_addr_1  output  3  port 1 address
data_in_0  output  16  port 0 data
data_in_1  output  16  port 1 data
pack_count  output  CNT_W  cycles in which two single writes were packed
conflict_count  output  CNT_W  cycles in which packing was refused due to address collision

Behaviour:
- Reset: all outputs 0 (write_mode 00), rr_ptr 0, both counters 0. Asserting rst mid-stream drops the registered write immediately; nothing accepted that cycle is retained.
- Handshake: transfer occurs when req_valid[i] & req_ready[i] at a rising edge. req_ready depends on req_valid; requesters must not gate valid on ready. A requester holds its payload stable while valid and not ready.
- Arbitration (combinational, each cycle). Scan order is rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - W = first valid requester in scan order.
  - W dual: grant W only.
    - addr0 != addr1: mode 11, port0 = (addr0, data0), port1 = (addr1, data1).
    - addr0 == addr1: mode 01, port0 = (addr0, data1), i.e. last-write-wins.
  - W single: S = next valid single requester after W in scan order with addr0 != W.addr0.
    - S found: grant W and S, mode 11, port0 = W, port1 = S.
    - Else: grant W only, mode 01.
    - Dual requesters are never paired with another requester.
  - No valid requester: no grant.
- Output stage: granted payload is registered at the accepting edge E. Outputs are valid during the cycle after E; the register file commits at edge E+1 (latency 1, throughput up to 2 registers per cycle).
- Idle cycle: reg_write_en 0, write_mode 00, addresses and data driven 0.
- reg_write_en = 1 exactly when write_mode != 00.
- rr_ptr update: on any grant, rr_ptr <= (highest-order granted index in scan order) + 1 modulo NUM_REQ; unchanged when no grant. Guarantees no valid requester waits more than NUM_REQ-1 grant cycles.
- pack_count: +1 on each packed cycle.
- conflict_count: +1 on a cycle where W is single, some other valid single requester exists, and every such candidate has addr0 == W.addr0.
- Both counters saturate at all-ones, never wrap.
- Writes from different requesters to the same register are never issued in one cycle. Ordering between requesters is decided solely by grant order.

Test Plan:
- Reset, then 3 idle cycles → all outputs 0, req_ready 000. Assert rst while a write is on the outputs → outputs 0 asynchronously, counters 0.
- Req0 single (r2, 0x1234) and req1 single (r5, 0xBEEF) valid together, rr_ptr 0 → req_ready 011. Next cycle: mode 11, addr0 2/data 0x1234, addr1 5/data 0xBEEF. pack_count 1. rr_ptr becomes 2.
- Req0 single r3 and req1 single r3 valid together → cycle 1: req0 only, mode 01, conflict_count 1. Next cycle: req1 granted, mode 01, r3.
- Req2 dual (r6 0xAAAA, r7 0x5555) with req0 single valid, rr_ptr 2 → req2 alone, mode 11 (6, 7). Next cycle: req0, mode 01.
- Dual request with addr0 = addr1 = r1, data0 0x1111, data1 0x2222 → mode 01, addr 1, data 0x2222.
- All three requesters single with distinct addresses, held valid for 20 cycles → grants rotate and no requester starves. pack_count saturates correctly with CNT_W=2 (stops at 3).
